// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with aligned sync, video_on and frame_start outputs
module vga_timing_gen #(
  parameter int H_VIDEO  = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_VIDEO  = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start
);
  localparam int H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VID  = 10'(H_VIDEO);
  localparam logic [9:0] V_VID  = 10'(V_VIDEO);
  localparam logic [9:0] HS_BEG = 10'(H_VIDEO + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VIDEO + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_VIDEO + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VIDEO + V_FRONT + V_SYNC - 1);
  logic [9:0] nx, ny;
  // next raster position; decoding it lets every registered output describe the same pixel
  always_comb begin
    nx = (pixel_x == H_LAST) ? '0 : pixel_x + 10'd1;
    ny = (pixel_x != H_LAST) ? pixel_y : (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
  end
  // raster state; reset parks on the last pixel so the first advance lands on (0, 0)
  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else if (pix_ce) begin
      pixel_x     <= nx;
      pixel_y     <= ny;
      video_on    <= (nx < H_VID) && (ny < V_VID);
      hsync       <= (nx >= HS_BEG && nx <= HS_END) ? SYNC_POL : ~SYNC_POL;
      vsync       <= (ny >= VS_BEG && ny <= VS_END) ? SYNC_POL : ~SYNC_POL;
      frame_start <= (nx == '0) && (ny == '0);
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the default 640x480 raster plus a small-raster instance for frame-level behaviour
module tb_vga_timing_gen;
  logic clk_0 = 1'b0;
  logic rst = 1'b0;
  logic ce_a = 1'b1;
  logic ce_b = 1'b1;
  logic [9:0] ax, ay, bx, by;
  logic avo, ahs, avs, afs, bvo, bhs, bvs, bfs;
  int checks = 0;
  int errors = 0;
  int mx, my, vs_cnt, ymax, run, max_run;
  int rises[$];
  int vo_cnt, hs_cnt, first_low, hs_rise;
  logic prev_hs;

  vga_timing_gen ua (
    .clk_0(clk_0), .rst(rst), .pix_ce(ce_a),
    .pixel_x(ax), .pixel_y(ay), .video_on(avo),
    .hsync(ahs), .vsync(avs), .frame_start(afs)
  );

  // small raster: 15x13 total, hsync x 10..12, vsync y 8..9, active-high syncs
  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
    .SYNC_POL(1'b1)
  ) ub (
    .clk_0(clk_0), .rst(rst), .pix_ce(ce_b),
    .pixel_x(bx), .pixel_y(by), .video_on(bvo),
    .hsync(bhs), .vsync(bvs), .frame_start(bfs)
  );

  always #5 clk_0 = ~clk_0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_0);
    #1;
  endtask

  task automatic run_b(input int n, input bit toggle);
    logic prev_fs;
    prev_fs = bfs;
    vs_cnt = 0;
    ymax = 0;
    run = 0;
    max_run = 0;
    rises.delete();
    for (int i = 0; i < n; i++) begin
      ce_b = toggle ? (i % 2 == 0) : 1'b1;
      tick();
      if (ce_b) begin
        if (mx == 14) begin
          mx = 0;
          my = (my == 12) ? 0 : my + 1;
        end else mx++;
      end
      check("b_x", bx, mx);
      check("b_y", by, my);
      check("b_video_on", bvo, (mx < 8 && my < 6));
      check("b_hsync", bhs, (mx >= 10 && mx <= 12));
      check("b_vsync", bvs, (my >= 8 && my <= 9));
      check("b_frame_start", bfs, (mx == 0 && my == 0));
      vs_cnt += bvs;
      if (by > ymax) ymax = by;
      if (bfs && !prev_fs) rises.push_back(i);
      run = bfs ? run + 1 : 0;
      if (run > max_run) max_run = run;
      prev_fs = bfs;
    end
  endtask

  initial begin
    repeat (5) tick();
    check("rst_a_x", ax, 799);
    check("rst_a_y", ay, 524);
    check("rst_a_video_on", avo, 0);
    check("rst_a_frame_start", afs, 0);
    check("rst_a_hsync", ahs, 1);
    check("rst_a_vsync", avs, 1);
    check("rst_b_x", bx, 14);
    check("rst_b_y", by, 12);
    check("rst_b_hsync", bhs, 0);
    check("rst_b_vsync", bvs, 0);
    check("rst_b_frame_start", bfs, 0);
    rst = 1'b1;
    tick();
    check("first_a_x", ax, 0);
    check("first_a_y", ay, 0);
    check("first_a_video_on", avo, 1);
    check("first_a_frame_start", afs, 1);
    check("first_a_hsync", ahs, 1);
    check("first_a_vsync", avs, 1);
    check("first_b_x", bx, 0);
    check("first_b_y", by, 0);
    check("first_b_frame_start", bfs, 1);
    ce_b = 1'b0;
    vo_cnt = 0;
    hs_cnt = 0;
    first_low = -1;
    hs_rise = -1;
    prev_hs = ahs;
    for (int i = 0; i < 800; i++) begin
      if (avo) vo_cnt++;
      if (!ahs) begin
        hs_cnt++;
        if (first_low < 0) first_low = ax;
      end else if (!prev_hs && hs_rise < 0) hs_rise = ax;
      prev_hs = ahs;
      tick();
    end
    check("line_x", ax, 0);
    check("line_y", ay, 1);
    check("line_video_on_count", vo_cnt, 640);
    check("line_hsync_low_count", hs_cnt, 96);
    check("line_hsync_first_low_x", first_low, 656);
    check("line_hsync_rise_x", hs_rise, 752);
    check("b_hold_x", bx, 0);
    check("b_hold_frame_start", bfs, 1);
    repeat (300) tick();
    check("mid_a_x", ax, 300);
    check("mid_a_y", ay, 1);
    #2 rst = 1'b0;
    #1;
    check("async_a_x", ax, 799);
    check("async_a_y", ay, 524);
    check("async_a_video_on", avo, 0);
    check("async_a_hsync", ahs, 1);
    check("async_a_vsync", avs, 1);
    check("async_a_frame_start", afs, 0);
    check("async_b_x", bx, 14);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("resume_a_x", ax, 0);
    check("resume_a_y", ay, 0);
    check("resume_a_frame_start", afs, 1);
    check("resume_a_video_on", avo, 1);
    ce_a = 1'b0;
    repeat (3) tick();
    check("hold_a_x", ax, 0);
    check("hold_a_y", ay, 0);
    check("hold_a_frame_start", afs, 1);
    ce_a = 1'b1;
    mx = 14;
    my = 12;
    run_b(391, 1'b0);
    check("frames_rises", rises.size(), 3);
    check("frames_first_rise", rises.size() > 0 ? rises[0] : -1, 0);
    check("frames_period", rises.size() > 1 ? rises[1] - rises[0] : -1, 195);
    check("frames_vsync_count", vs_cnt, 60);
    check("frames_y_max", ymax, 12);
    run_b(781, 1'b1);
    check("ce_rises", rises.size(), 2);
    check("ce_first_rise", rises.size() > 0 ? rises[0] : -1, 388);
    check("ce_period", rises.size() > 1 ? rises[1] - rises[0] : -1, 390);
    check("ce_frame_start_width", max_run, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
